// File: rtl/cache_backing_mem_responder_if.sv
// cache_backing_mem_responder_if: request/response bus between a requester (master) and the memory responder (slave)
//   req_*  : request channel, valid/ready handshake, driven by the master
//   rsp_*  : response channel, valid/ready handshake, driven by the slave
interface cache_backing_mem_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/cache_backing_mem_responder.sv
// cache_backing_mem_responder: single-outstanding main-memory model with fixed access latency
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, also clears the whole memory
//   bus   : slave side of the request/response interface
//   busy  : high whenever the FSM is not in IDLE
module cache_backing_mem_responder #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cache_backing_mem_responder_if.slave  bus,
  output logic                          busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_d       = mem_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        we_d    = bus.req_we;
        cnt_d   = CNT_INIT;
        state_d = WAIT;
        // write commits at acceptance so a following read sees it
        if (bus.req_we) mem_d[bus.req_addr] = bus.req_wdata;
      end
      WAIT: if (cnt_q == '0) begin
        state_d     = RESP;
        rsp_we_d    = we_q;
        rsp_rdata_d = we_q ? '0 : mem_q[addr_q];
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (bus.rsp_ready) begin
        state_d     = IDLE;
        rsp_we_d    = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_q       <= mem_d;
    end
  end
  // handshake outputs depend on state only, never on inputs
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_cache_backing_mem_responder.sv
// tb_cache_backing_mem_responder: table-driven directed checks of the memory responder
module tb_cache_backing_mem_responder;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int n_cmp = 0;
  int n_bad = 0;
  cache_backing_mem_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();
  cache_backing_mem_responder #(.ADDR_W(4), .DATA_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         bp;
    logic       exp_we;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs [11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic txn(input logic we, input logic [3:0] addr, input logic [7:0] wdata, input int bp,
                     output logic rwe, output logic [7:0] rdata);
    int n;
    @(negedge clk);
    chk("req_ready_before", 32'(bus.req_ready), 1);
    bus.rsp_ready = (bp == 0);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.rsp_valid) break;
    end
    rwe   = bus.rsp_we;
    rdata = bus.rsp_rdata;
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    chk("latency", n, LAT);
    chk("req_ready_in_resp", 32'(bus.req_ready), 0);
    chk("busy_in_resp", 32'(busy), 1);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rdata_stable", 32'(bus.rsp_rdata), 32'(rdata));
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid_after_hs", 32'(bus.rsp_valid), 0);
    chk("req_ready_after_hs", 32'(bus.req_ready), 1);
    chk("rdata_cleared", 32'(bus.rsp_rdata), 0);
    chk("busy_after_hs", 32'(busy), 0);
  endtask
  initial begin
    logic rwe;
    logic [7:0] rdata;
    int n;
    vecs[0]  = '{1'b0, 4'h5, 8'h00, 0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 4'hB, 8'hA5, 0, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 4'hB, 8'h00, 0, 1'b0, 8'hA5};
    vecs[3]  = '{1'b1, 4'h2, 8'h3C, 0, 1'b1, 8'h00};
    vecs[4]  = '{1'b0, 4'h2, 8'h00, 5, 1'b0, 8'h3C};
    vecs[5]  = '{1'b1, 4'h0, 8'h11, 0, 1'b1, 8'h00};
    vecs[6]  = '{1'b1, 4'hF, 8'hFF, 0, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 4'h0, 8'h00, 0, 1'b0, 8'h11};
    vecs[8]  = '{1'b0, 4'hF, 8'h00, 0, 1'b0, 8'hFF};
    vecs[9]  = '{1'b0, 4'h1, 8'h00, 0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 4'hE, 8'h00, 1, 1'b0, 8'h00};
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_rsp_we", 32'(bus.rsp_we), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].bp, rwe, rdata);
      chk($sformatf("vec%0d_rsp_we", i), 32'(rwe), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
    end
    // request offered while WAIT must be ignored
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'h3;
    @(posedge clk);
    #1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'h7;
    bus.req_wdata = 8'h99;
    @(negedge clk);
    chk("ign_req_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (n < 20 && !bus.rsp_valid) begin
      @(negedge clk);
      n++;
    end
    chk("ign_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("ign_rsp_we", 32'(bus.rsp_we), 0);
    chk("ign_rdata", 32'(bus.rsp_rdata), 0);
    @(posedge clk);
    txn(1'b0, 4'h7, 8'h00, 0, rwe, rdata);
    chk("ign_read7", 32'(rdata), 0);
    // reset while the accepted write is still in WAIT
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'h4;
    bus.req_wdata = 8'h77;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_rdata", 32'(bus.rsp_rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(bus.rsp_valid), 0);
    end
    txn(1'b0, 4'h4, 8'h00, 0, rwe, rdata);
    chk("mid_read4", 32'(rdata), 0);
    txn(1'b0, 4'hB, 8'h00, 0, rwe, rdata);
    chk("mid_readB_cleared", 32'(rdata), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
